// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: ALU op encodings and flag bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_MOV = 3'd6,
    OP_INC = 3'd7
  } alu_op_e;

  localparam int FLAG_O = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_W = 3;

  function automatic logic isArith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/datapath_pipe_alu_core.sv
// Combinational ALU for datapath_pipe: result plus overflow / zero / negative flags.
module alu_core
  import datapath_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] result_o,
  output logic         o_o,
  output logic         z_o,
  output logic         n_o
);

  logic [N-1:0] res;
  logic         ovf;

  // Signed overflow only exists for the arithmetic ops; logic ops and MOV never set it.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_i)
      OP_ADD: begin
        res = a_i + b_i;
        ovf = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        res = a_i - b_i;
        ovf = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~a_i;
      OP_MOV: res = a_i;
      OP_INC: begin
        res = a_i + {{(N-1){1'b0}}, 1'b1};
        ovf = !a_i[N-1] && res[N-1];
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  assign result_o = res;
  assign o_o      = ovf && isArith(op_i);
  assign z_o      = (res == '0);
  assign n_o      = res[N-1];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage pipelined datapath: S1 reads the register file into S2 operand regs, S2 executes and writes back.
// Build option: define FORWARD_EN to forward the in-flight S2 write instead of stalling issue for one cycle.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [2:0]   op_i,
  input  logic         ie_i,
  input  logic         write_i,
  input  logic [M-1:0] waddr_i,
  input  logic [M-1:0] ra_i,
  input  logic [M-1:0] rb_i,
  input  logic         bypassa_i,
  input  logic         bypassb_i,
  input  logic [N-1:0] din_i,
  input  logic [N-1:0] offset_i,
  output logic [N-1:0] dout_o,
  output logic         dout_valid_o,
  output logic         o_flag_o,
  output logic         z_flag_o,
  output logic         n_flag_o
);

  localparam int DEPTH = 1 << M;

  logic [N-1:0]      rf_q [DEPTH];

  logic              s2Valid_q;
  alu_op_e           s2Op_q;
  logic              s2Ie_q;
  logic              s2Write_q;
  logic [M-1:0]      s2Waddr_q;
  logic [N-1:0]      s2Din_q;
  logic [N-1:0]      s2A_q;
  logic [N-1:0]      s2B_q;

  logic [N-1:0]      dout_q;
  logic              doutValid_q;
  logic [FLAG_W-1:0] flags_q;

  logic [N-1:0]      aluResult;
  logic              aluO;
  logic              aluZ;
  logic              aluN;
  logic [N-1:0]      s2WrData;

  logic              hazardA;
  logic              hazardB;
  logic              fwdA;
  logic              fwdB;
  logic              issue;
  logic [N-1:0]      opA_d;
  logic [N-1:0]      opB_d;

  alu_core #(.N(N)) u_alu (
    .a_i      (s2A_q),
    .b_i      (s2B_q),
    .op_i     (s2Op_q),
    .result_o (aluResult),
    .o_o      (aluO),
    .z_o      (aluZ),
    .n_o      (aluN)
  );

  assign s2WrData = s2Ie_q ? s2Din_q : aluResult;

  // A bypassed operand never touches the RF, so it can never be hazarded.
  assign hazardA = s2Valid_q && s2Write_q && !bypassa_i && (ra_i == s2Waddr_q);
  assign hazardB = s2Valid_q && s2Write_q && !bypassb_i && (rb_i == s2Waddr_q);

`ifdef FORWARD_EN
  assign in_ready_o = 1'b1;
  assign fwdA       = hazardA;
  assign fwdB       = hazardB;
`else
  assign in_ready_o = !(in_valid_i && (hazardA || hazardB));
  assign fwdA       = 1'b0;
  assign fwdB       = 1'b0;
`endif

  assign issue = in_valid_i && in_ready_o;

  always_comb begin
    opA_d = rf_q[ra_i];
    opB_d = rf_q[rb_i];
    if (fwdA) opA_d = s2WrData;
    if (fwdB) opB_d = s2WrData;
    if (bypassa_i) opA_d = offset_i;
    if (bypassb_i) opB_d = offset_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (s2Valid_q && s2Write_q) begin
      rf_q[s2Waddr_q] <= s2WrData;
    end
  end

  // Payload regs only load on issue; s2Valid_q alone marks a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2Valid_q <= 1'b0;
      s2Op_q    <= OP_ADD;
      s2Ie_q    <= 1'b0;
      s2Write_q <= 1'b0;
      s2Waddr_q <= '0;
      s2Din_q   <= '0;
      s2A_q     <= '0;
      s2B_q     <= '0;
    end else begin
      s2Valid_q <= issue;
      if (issue) begin
        s2Op_q    <= alu_op_e'(op_i);
        s2Ie_q    <= ie_i;
        s2Write_q <= write_i;
        s2Waddr_q <= waddr_i;
        s2Din_q   <= din_i;
        s2A_q     <= opA_d;
        s2B_q     <= opB_d;
      end
    end
  end

  // Input-enable instructions only load the RF; dout and flags keep the last ALU result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      doutValid_q <= s2Valid_q && !s2Ie_q;
      if (s2Valid_q && !s2Ie_q) begin
        dout_q          <= aluResult;
        flags_q[FLAG_O] <= aluO;
        flags_q[FLAG_Z] <= aluZ;
        flags_q[FLAG_N] <= aluN;
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = doutValid_q;
  assign o_flag_o     = flags_q[FLAG_O];
  assign z_flag_o     = flags_q[FLAG_Z];
  assign n_flag_o     = flags_q[FLAG_N];

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: sequential architectural model predicts each ALU result at issue.
// Honours FORWARD_EN the same way as the design for the expected stall count.
module tb_datapath_pipe;

`ifdef FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       ie;
  logic       write;
  logic [2:0] waddr;
  logic [2:0] ra;
  logic [2:0] rb;
  logic       bypassa;
  logic       bypassb;
  logic [7:0] din;
  logic [7:0] offset;
  logic [7:0] dout;
  logic       dout_valid;
  logic       o_flag;
  logic       z_flag;
  logic       n_flag;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0]  modelRf [8];
  logic [10:0] expQ [$];
  logic [10:0] holdExp = '0;

  datapath_pipe #(.M(3), .N(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .op_i         (op),
    .ie_i         (ie),
    .write_i      (write),
    .waddr_i      (waddr),
    .ra_i         (ra),
    .rb_i         (rb),
    .bypassa_i    (bypassa),
    .bypassb_i    (bypassb),
    .din_i        (din),
    .offset_i     (offset),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .o_flag_o     (o_flag),
    .z_flag_o     (z_flag),
    .n_flag_o     (n_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference ALU from signed integer arithmetic: overflow is "true result outside -128..127".
  function automatic void refAlu(input int opc, input int a, input int b, output int res, output bit ovf);
    int sa, sb, full;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (opc)
      0: full = sa + sb;
      1: full = sa - sb;
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = ~a;
      6: full = a;
      default: full = sa + 1;
    endcase
    res = full & 255;
    ovf = (opc == 0 || opc == 1 || opc == 7) && (full > 127 || full < -128);
  endfunction

  function automatic void modelIssue();
    int a, b, res;
    bit ovf;
    a = bypassa ? int'(offset) : int'(modelRf[ra]);
    b = bypassb ? int'(offset) : int'(modelRf[rb]);
    refAlu(int'(op), a, b, res, ovf);
    if (write) modelRf[waddr] = ie ? din : 8'(res);
    if (!ie) expQ.push_back({8'(res), ovf, res == 0, res > 127});
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic i, input logic w, input logic [2:0] wa,
                               input logic [2:0] a, input logic [2:0] b, input logic ba, input logic bb,
                               input logic [7:0] d, input logic [7:0] off, output int stalls);
    bit issued;
    @(negedge clk);
    op = o; ie = i; write = w; waddr = wa; ra = a; rb = b;
    bypassa = ba; bypassb = bb; din = d; offset = off;
    in_valid = 1'b1;
    stalls = 0;
    issued = 0;
    for (int c = 0; c < 6 && !issued; c++) begin
      #1;
      if (in_ready) begin
        modelIssue();
        issued = 1;
        @(posedge clk);
        #1;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!issued) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL issue timeout: in_ready stayed 0 for %0d cycles, expected issue", stalls);
    end
  endtask

  task automatic expectLast(input string name, input logic [7:0] d, input logic o, input logic z, input logic n);
    @(posedge clk);
    #1;
    checkOutput({name, " dout"}, dout, d);
    checkOutput({name, " flags ozn"}, {o_flag, z_flag, n_flag}, {o, z, n});
  endtask

  task automatic doReset();
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) modelRf[i] = '0;
    #1;
    checkOutput("reset dout", dout, 0);
    checkOutput("reset flags", {o_flag, z_flag, n_flag}, 0);
    checkOutput("reset dout_valid", dout_valid, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one prediction per dout_valid pulse; otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      holdExp = '0;
    end else if (dout_valid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected dout_valid: dout=%0h with empty scoreboard", dout);
      end else begin
        holdExp = expQ.pop_front();
        checkOutput("sb dout", dout, holdExp[10:3]);
        checkOutput("sb flags ozn", {o_flag, z_flag, n_flag}, holdExp[2:0]);
      end
    end else begin
      checkOutput("hold dout+flags", {dout, o_flag, z_flag, n_flag}, holdExp);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = '0; ie = 0; write = 0; waddr = '0; ra = '0; rb = '0;
    bypassa = 0; bypassb = 0; din = '0; offset = '0;
    for (int i = 0; i < 8; i++) modelRf[i] = '0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(3'd0, 0, 0, 3'd0, 3'd0, 3'd0, 1, 1, 8'h00, 8'h23, st);
    expectLast("pre-reset add", 8'h46, 0, 0, 0);
    applyStimulus(3'd0, 0, 1, 3'd1, 3'd0, 3'd0, 1, 1, 8'h00, 8'h11, st);
    doReset();
    applyStimulus(3'd6, 0, 0, 3'd0, 3'd1, 3'd0, 0, 0, 8'h00, 8'h00, st);
    expectLast("R1 after reset", 8'h00, 0, 1, 0);

    applyStimulus(3'd0, 1, 1, 3'd1, 3'd0, 3'd0, 0, 0, 8'h7F, 8'h00, st);
    applyStimulus(3'd0, 0, 1, 3'd2, 3'd1, 3'd0, 0, 1, 8'h00, 8'h01, st);
    expectLast("add ovf", 8'h80, 1, 0, 1);
    applyStimulus(3'd1, 0, 1, 3'd3, 3'd1, 3'd1, 0, 0, 8'h00, 8'h00, st);
    expectLast("sub self", 8'h00, 0, 1, 0);
    applyStimulus(3'd0, 1, 1, 3'd7, 3'd0, 3'd0, 0, 0, 8'hFF, 8'h00, st);
    applyStimulus(3'd7, 0, 1, 3'd7, 3'd7, 3'd0, 0, 0, 8'h00, 8'h00, st);
    expectLast("inc wrap", 8'h00, 0, 1, 0);

    applyStimulus(3'd0, 0, 1, 3'd4, 3'd1, 3'd1, 0, 0, 8'h00, 8'h00, st);
    applyStimulus(3'd0, 0, 1, 3'd5, 3'd4, 3'd4, 0, 0, 8'h00, 8'h00, st);
    checkOutput("dependent pair stalls", st, EXP_STALL);
    expectLast("dependent pair", 8'hFC, 0, 0, 1);

    applyStimulus(3'd0, 1, 1, 3'd6, 3'd0, 3'd0, 0, 0, 8'h10, 8'h00, st);
    applyStimulus(3'd0, 0, 0, 3'd0, 3'd6, 3'd6, 1, 1, 8'h00, 8'h05, st);
    checkOutput("bypassed operands stalls", st, 0);
    expectLast("bypassed add", 8'h0A, 0, 0, 0);

    applyStimulus(3'd0, 0, 1, 3'd6, 3'd6, 3'd6, 0, 0, 8'h00, 8'h00, st);
    expectLast("ra=rb=waddr", 8'h20, 0, 0, 0);
    applyStimulus(3'd6, 0, 0, 3'd0, 3'd6, 3'd0, 0, 0, 8'h00, 8'h00, st);
    expectLast("ra=rb=waddr readback", 8'h20, 0, 0, 0);

    applyStimulus(3'd2, 1, 1, 3'd2, 3'd0, 3'd0, 0, 0, 8'h33, 8'h00, st);
    repeat (4) @(negedge clk);
    checkOutput("ie keeps dout", dout, 8'h20);
    applyStimulus(3'd6, 0, 0, 3'd0, 3'd2, 3'd0, 0, 0, 8'h00, 8'h00, st);
    expectLast("ie write readback", 8'h33, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      logic [2:0] ro, rwa, rra, rrb;
      logic ri, rw, rba, rbb;
      logic [7:0] rd, roff;
      ro = 3'($urandom_range(0, 7));
      ri = ($urandom_range(0, 3) == 0);
      rw = ($urandom_range(0, 3) != 0);
      rwa = 3'($urandom_range(0, 7));
      rra = 3'($urandom_range(0, 7));
      rrb = 3'($urandom_range(0, 7));
      rba = ($urandom_range(0, 3) == 0);
      rbb = ($urandom_range(0, 3) == 0);
      rd = 8'($urandom);
      roff = 8'($urandom);
      applyStimulus(ro, ri, rw, rwa, rra, rrb, rba, rbb, rd, roff, st);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
